// File: rtl/i2c_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2c_data_fifo
// Desc     : Synchronous first-word-fall-through FIFO with sticky error flags,
//            used on both the TX and RX data paths behind the APB slave.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_data_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  CLEAR,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    output logic                  ERROR
);

    localparam int                    c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE   = (ADDR_WIDTH)'(1);

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_run;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;
    logic w_unf_set;

    // Reset and flush both swallow any access presented in the same cycle.
    assign w_run     = PRESETn & ~CLEAR;
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_empty   = (r_count == '0);

    // A pop on a full FIFO frees the slot, so the concurrent push is legal.
    assign w_push    = w_run & WR_EN & (~w_full | RD_EN);
    assign w_pop     = w_run & RD_EN & ~w_empty;
    assign w_ovf_set = w_run & WR_EN & w_full & ~RD_EN;
    assign w_unf_set = w_run & RD_EN & w_empty;

    always_ff @(posedge PCLK) begin
        if (!PRESETn || CLEAR) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are meaningless while EMPTY is high.
    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= DATA_IN;
        end
    end

    assign DATA_OUT    = r_mem[r_rptr];
    assign FULL        = w_full;
    assign EMPTY       = w_empty;
    assign ALMOST_FULL = (r_count >= c_AFULL_CNT);
    assign COUNT       = r_count;
    assign OVERFLOW    = r_ovf;
    assign UNDERFLOW   = r_unf;
    assign ERROR       = r_ovf | r_unf;

endmodule
`default_nettype wire

// File: tb/tb_i2c_data_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_data_fifo
// Desc     : Scoreboard-based bench for i2c_data_fifo (default 8 x 32 config).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_data_fifo;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        CLEAR = 1'b0;
    logic        WR_EN = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic        RD_EN = 1'b0;
    logic [31:0] DATA_OUT;
    logic        FULL;
    logic        EMPTY;
    logic        ALMOST_FULL;
    logic [3:0]  COUNT;
    logic        OVERFLOW;
    logic        UNDERFLOW;
    logic        ERROR;

    logic [31:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    i2c_data_fifo #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3),
        .AFULL_LEVEL(6)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .CLEAR      (CLEAR),
        .WR_EN      (WR_EN),
        .DATA_IN    (DATA_IN),
        .RD_EN      (RD_EN),
        .DATA_OUT   (DATA_OUT),
        .FULL       (FULL),
        .EMPTY      (EMPTY),
        .ALMOST_FULL(ALMOST_FULL),
        .COUNT      (COUNT),
        .OVERFLOW   (OVERFLOW),
        .UNDERFLOW  (UNDERFLOW),
        .ERROR      (ERROR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // One clock with the given request; the model mirrors the FIFO contract.
    task automatic tick(input logic wr, input logic [31:0] din, input logic rd);
        bit m_empty;
        bit m_full;
        m_empty = (sb.size() == 0);
        m_full  = (sb.size() == 8);
        WR_EN   = wr;
        DATA_IN = din;
        RD_EN   = rd;
        @(posedge PCLK);
        #1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        if (rd && !m_empty) void'(sb.pop_front());
        if (wr && (!m_full || rd)) sb.push_back(din);
    endtask

    task automatic do_clear(input logic wr);
        CLEAR   = 1'b1;
        WR_EN   = wr;
        DATA_IN = 32'hBAD0_BAD0;
        @(posedge PCLK);
        #1;
        CLEAR = 1'b0;
        WR_EN = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        sb.delete();
        n_tests++;
        if (EMPTY !== 1'b1 || FULL !== 1'b0 || ALMOST_FULL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got E=%0d F=%0d AF=%0d required E=1 F=0 AF=0",
                     EMPTY, FULL, ALMOST_FULL);
        end
        n_tests++;
        if (COUNT !== 4'd0 || ERROR !== 1'b0 || OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count_err: got COUNT=%0d ERR=%0d OVF=%0d UNF=%0d required 0 0 0 0",
                     COUNT, ERROR, OVERFLOW, UNDERFLOW);
        end
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        tick(1'b1, words[0], 1'b0);
        n_tests++;
        if (DATA_OUT !== 32'h1111_1111 || EMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first_word: got DATA_OUT=%h EMPTY=%0d required 11111111 0",
                     DATA_OUT, EMPTY);
        end
        tick(1'b1, words[1], 1'b0);
        tick(1'b1, words[2], 1'b0);
        n_tests++;
        if (COUNT !== 4'd3 || EMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count3: got COUNT=%0d EMPTY=%0d required 3 0", COUNT, EMPTY);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (sb.size() == 0 || DATA_OUT !== sb[0]) begin
                n_fail++;
                $display("FAIL basic_pop_%0d: got %h required %h", i, DATA_OUT,
                         (sb.size() == 0) ? 32'h0 : sb[0]);
            end
            tick(1'b0, 32'h0, 1'b1);
        end
        n_tests++;
        if (EMPTY !== 1'b1 || COUNT !== 4'd0 || ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drained: got EMPTY=%0d COUNT=%0d ERROR=%0d required 1 0 0",
                     EMPTY, COUNT, ERROR);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 32'hA0 + 32'(i), 1'b0);
            n_tests++;
            if (COUNT !== 4'(i + 1) || ALMOST_FULL !== (i + 1 >= 6) || FULL !== (i + 1 == 8)) begin
                n_fail++;
                $display("FAIL fill_%0d: got COUNT=%0d AF=%0d FULL=%0d required %0d %0d %0d",
                         i, COUNT, ALMOST_FULL, FULL, i + 1, (i + 1 >= 6), (i + 1 == 8));
            end
        end
        tick(1'b1, 32'hFF, 1'b0);
        n_tests++;
        if (OVERFLOW !== 1'b1 || ERROR !== 1'b1 || COUNT !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow_set: got OVF=%0d ERR=%0d COUNT=%0d required 1 1 8",
                     OVERFLOW, ERROR, COUNT);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (sb.size() == 0 || DATA_OUT !== sb[0]) begin
                n_fail++;
                $display("FAIL overflow_pop_%0d: got %h required %h", i, DATA_OUT,
                         (sb.size() == 0) ? 32'h0 : sb[0]);
            end
            tick(1'b0, 32'h0, 1'b1);
        end
        n_tests++;
        if (EMPTY !== 1'b1 || OVERFLOW !== 1'b1 || UNDERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_sticky: got EMPTY=%0d OVF=%0d UNF=%0d required 1 1 0",
                     EMPTY, OVERFLOW, UNDERFLOW);
        end
        do_clear(1'b0);
        n_tests++;
        if (OVERFLOW !== 1'b0 || ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got OVF=%0d ERR=%0d required 0 0", OVERFLOW, ERROR);
        end
    endtask

    task automatic test_back_to_back_full();
        for (int i = 0; i < 8; i++) tick(1'b1, 32'hD0 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (DATA_OUT !== sb[0]) begin
                n_fail++;
                $display("FAIL full_rw_head_%0d: got %h required %h", i, DATA_OUT, sb[0]);
            end
            tick(1'b1, 32'hB0 + 32'(i), 1'b1);
            n_tests++;
            if (COUNT !== 4'd8 || OVERFLOW !== 1'b0 || FULL !== 1'b1) begin
                n_fail++;
                $display("FAIL full_rw_%0d: got COUNT=%0d OVF=%0d FULL=%0d required 8 0 1",
                         i, COUNT, OVERFLOW, FULL);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (DATA_OUT !== 32'hB2 + 32'(i) || sb.size() == 0 || DATA_OUT !== sb[0]) begin
                n_fail++;
                $display("FAIL full_rw_drain_%0d: got %h required %h", i, DATA_OUT,
                         32'hB2 + 32'(i));
            end
            tick(1'b0, 32'h0, 1'b1);
        end
        n_tests++;
        if (EMPTY !== 1'b1 || ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rw_end: got EMPTY=%0d ERROR=%0d required 1 0", EMPTY, ERROR);
        end
    endtask

    task automatic test_empty_underflow();
        tick(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (UNDERFLOW !== 1'b1 || COUNT !== 4'd0 || EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_pop: got UNF=%0d COUNT=%0d EMPTY=%0d required 1 0 1",
                     UNDERFLOW, COUNT, EMPTY);
        end
        do_clear(1'b0);
        tick(1'b1, 32'hC5, 1'b1);
        n_tests++;
        if (COUNT !== 4'd1 || DATA_OUT !== 32'hC5 || UNDERFLOW !== 1'b1 || ERROR !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_rw: got COUNT=%0d DATA=%h UNF=%0d ERR=%0d required 1 c5 1 1",
                     COUNT, DATA_OUT, UNDERFLOW, ERROR);
        end
        do_clear(1'b1);
        n_tests++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1 || UNDERFLOW !== 1'b0 ||
            OVERFLOW !== 1'b0 || ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flush: got COUNT=%0d EMPTY=%0d UNF=%0d OVF=%0d ERR=%0d required 0 1 0 0 0",
                     COUNT, EMPTY, UNDERFLOW, OVERFLOW, ERROR);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) tick(1'b1, 32'hE0 + 32'(i), 1'b0);
        n_tests++;
        if (COUNT !== 4'd4) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got COUNT=%0d required 4", COUNT);
        end
        PRESETn = 1'b0;
        WR_EN   = 1'b1;
        DATA_IN = 32'hDEAD_BEEF;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        WR_EN   = 1'b0;
        sb.delete();
        n_tests++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_flush: got COUNT=%0d EMPTY=%0d required 0 1", COUNT, EMPTY);
        end
        tick(1'b1, 32'h1234_5678, 1'b0);
        n_tests++;
        if (COUNT !== 4'd1 || DATA_OUT !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reset_mid_resume: got COUNT=%0d DATA=%h required 1 12345678",
                     COUNT, DATA_OUT);
        end
        tick(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (EMPTY !== 1'b1 || ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got EMPTY=%0d ERROR=%0d required 1 0", EMPTY, ERROR);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overflow();
        test_back_to_back_full();
        test_empty_underflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_data_fifo.md
Name: i2c_data_fifo

Overview:
- Synchronous first-word-fall-through FIFO that sits directly downstream of the APB slave interface.
- It is instantiated twice:
  - TX path: the APB side pushes `WR_ENA`/`WRITE_DATA_ON_TX`; the I2C core pops.
  - RX path: the I2C core pushes; the APB side pops through `RD_ENA` and reads `READ_DATA_ON_RX`.
- Provides the `TX_EMPTY`/`RX_EMPTY` interrupt sources and the error source for `PSLVERR`.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 entries).
- AFULL_LEVEL, 6, COUNT at or above which ALMOST_FULL asserts; legal range is 1..DEPTH-1.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  synchronous active-low reset.
- CLEAR  in  1  synchronous flush, active high.
- WR_EN  in  1  push request; samples DATA_IN this edge.
- DATA_IN  in  DATA_WIDTH  word to push.
- RD_EN  in  1  pop request; advances the head this edge.
- DATA_OUT  out  DATA_WIDTH  current head word; valid while EMPTY=0.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AFULL_LEVEL.
- COUNT  out  ADDR_WIDTH+1  number of stored words.
- OVERFLOW  out  1  sticky: a push was attempted while full.
- UNDERFLOW  out  1  sticky: a pop was attempted while empty.
- ERROR  out  1  OVERFLOW | UNDERFLOW.

Behaviour:
- Storage and pointers:
  - Register array of DEPTH words.
  - Write pointer and read pointer are ADDR_WIDTH bits and wrap modulo DEPTH.
  - COUNT is held in a separate (ADDR_WIDTH+1)-bit register.
- Reset (PRESETn=0 at a rising edge):
  - Pointers = 0, COUNT = 0, OVERFLOW = UNDERFLOW = 0.
  - Resulting outputs: EMPTY=1, FULL=0, ALMOST_FULL=0, ERROR=0.
  - Memory contents are not reset; DATA_OUT is don't-care while EMPTY=1.
- Reset or CLEAR mid-operation:
  - Any push or pop presented in that same cycle is discarded.
  - CLEAR also clears the sticky flags.
  - PRESETn has priority over CLEAR.
- Push: when WR_EN=1 and FULL=0, write DATA_IN at the write pointer and increment the write pointer.
- Pop: when RD_EN=1 and EMPTY=0, increment the read pointer.
- DATA_OUT:
  - Combinational read of mem[read pointer], so it shows the head word with zero added latency.
  - A word pushed at edge N appears on DATA_OUT after edge N when the FIFO was empty; write-to-DATA_OUT latency is 1 cycle.
- COUNT update:
  - Push only: +1.
  - Pop only: -1.
  - Both accepted: unchanged.
  - Neither: unchanged.
- Simultaneous WR_EN and RD_EN:
  - Empty: push accepted, pop rejected; UNDERFLOW sets; COUNT becomes 1.
  - Full: both accepted (the pop frees the slot); COUNT stays DEPTH; OVERFLOW not set.
  - Otherwise: both accepted.
- Overflow: WR_EN=1 while full with no accepted pop drops DATA_IN; memory and pointers are unchanged; OVERFLOW sets and holds.
- Underflow: RD_EN=1 while empty leaves pointers and COUNT unchanged; UNDERFLOW sets and holds.
- Sticky-flag clearing: only PRESETn or CLEAR clears OVERFLOW/UNDERFLOW.
- Flag timing: FULL, EMPTY and ALMOST_FULL are decoded from the registered COUNT, so they update in the same cycle COUNT changes.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no loss of data or ordering.
- Upstream behaviour: the APB interface holds WR_EN/RD_EN high for exactly one cycle per access (the enable phase), so each APB transfer moves exactly one word.

Test Plan:
- Reset, then push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles:
  - DATA_OUT = 0x11111111 one cycle after the first push.
  - COUNT = 3, EMPTY = 0.
- Pop 3 times:
  - DATA_OUT steps 0x22222222 then 0x33333333.
  - Then EMPTY = 1, COUNT = 0, ERROR = 0.
- Fill with 8 words 0xA0..0xA7:
  - ALMOST_FULL rises at COUNT = 6; FULL = 1 at 8.
  - Push 0xFF: dropped, OVERFLOW = 1.
  - Pop all 8: order is 0xA0..0xA7 and 0xFF never appears.
- Full FIFO, WR_EN = RD_EN = 1 with 0xB0 for 10 cycles:
  - COUNT stays 8, OVERFLOW stays 0, pointers wrap.
  - Subsequent pops return the correct FIFO order ending in 0xB0 values.
- Empty FIFO, WR_EN = RD_EN = 1 with 0xC5:
  - COUNT = 1, DATA_OUT = 0xC5, UNDERFLOW = 1, ERROR = 1.
  - Assert CLEAR for 1 cycle: COUNT = 0, EMPTY = 1, flags = 0.
- Push 4 words, then drive PRESETn = 0 for one edge while WR_EN = 1:
  - COUNT = 0, EMPTY = 1.
  - The concurrent push is discarded.
  - Normal operation resumes on the next edge.
